hella_cache_master_core: RTL and testbench

HELLA_CACHE_MASTER_CORE -- requirements
Module: hella_cache_master_core

---
 rtl/hella_cache_master_core.sv | 130 +++++++++++++
 tb/tb_hella_cache_master_core.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hella_cache_master_core.sv
// hella_cache_master_core: issues one host command at a time to a cache port
// and captures the cache response. IDLE accepts a command, REQ holds it until
// the cache takes it, and GAP adds one quiet cycle before the next command.
module hella_cache_master_core #(
  parameter int NUM_ADDR_BITS = 32,
  parameter int NUM_DATA_BITS = 32,
  parameter int NUM_TAG_BITS  = 7
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [NUM_ADDR_BITS-1:0]   cmd_addr,
  input  logic [NUM_TAG_BITS-1:0]    cmd_tag,
  input  logic [4:0]                 cmd_cmd,
  input  logic [2:0]                 cmd_typ,
  input  logic [NUM_DATA_BITS-1:0]   cmd_data,
  input  logic [NUM_DATA_BITS/8-1:0] cmd_mask,
  input  logic                       kill_clear,
  output logic [NUM_ADDR_BITS-1:0]   req_addr,
  input  logic                       req_ready,
  output logic                       req_valid,
  output logic [NUM_TAG_BITS-1:0]    req_tag,
  output logic [4:0]                 req_cmd,
  output logic [2:0]                 req_typ,
  output logic [NUM_DATA_BITS-1:0]   req_data,
  output logic [NUM_DATA_BITS/8-1:0] req_data_mask,
  output logic                       req_kill,
  input  logic                       rsp_valid,
  input  logic                       rsp_nack,
  input  logic [NUM_TAG_BITS-1:0]    rsp_tag,
  input  logic [2:0]                 rsp_typ,
  input  logic [NUM_DATA_BITS-1:0]   rsp_data,
  output logic                       out_valid,
  output logic                       out_nack,
  output logic [NUM_TAG_BITS-1:0]    out_tag,
  output logic [2:0]                 out_typ,
  output logic [NUM_DATA_BITS-1:0]   out_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic accept;
  logic handshake;

  assign accept    = (state == S_IDLE) && cmd_valid;
  assign handshake = (state == S_REQ) && req_ready;

  // Held low while reset is asserted even though the state is already IDLE.
  assign cmd_ready = (state == S_IDLE) && !reset;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; GAP always falls through to IDLE after one cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (cmd_valid) state_nxt = S_REQ;
      S_REQ:   if (req_ready) state_nxt = S_GAP;
      S_GAP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request registers: load on accept, clear on handshake. req_data is left
  // as-is after the handshake so the last store data stays observable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_valid     <= 1'b0;
      req_addr      <= '0;
      req_tag       <= '0;
      req_cmd       <= '0;
      req_typ       <= '0;
      req_data      <= '0;
      req_data_mask <= '0;
    end else if (accept) begin
      req_valid     <= 1'b1;
      req_addr      <= cmd_addr;
      req_tag       <= cmd_tag;
      req_cmd       <= cmd_cmd;
      req_typ       <= cmd_typ;
      req_data      <= cmd_data;
      req_data_mask <= cmd_mask;
    end else if (handshake) begin
      req_valid     <= 1'b0;
      req_addr      <= '0;
      req_tag       <= '0;
      req_cmd       <= '0;
      req_typ       <= '0;
      req_data_mask <= '0;
    end
  end

  // Kill flag: a nack wins over any clear arriving on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                        req_kill <= 1'b0;
    else if (rsp_nack)                req_kill <= 1'b1;
    else if (kill_clear || handshake) req_kill <= 1'b0;
  end

  // Response capture: out_valid pulses one cycle, captured fields hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_nack  <= 1'b0;
      out_tag   <= '0;
      out_typ   <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= rsp_valid || rsp_nack;
      if (rsp_valid || rsp_nack) begin
        out_nack <= rsp_nack;
        out_tag  <= rsp_tag;
        out_typ  <= rsp_typ;
        out_data <= rsp_data;
      end
    end
  end

endmodule

// File: tb/tb_hella_cache_master_core.sv
// Bench for hella_cache_master_core: table-driven command and response
// vectors, scoreboards for the request and response paths, and hand-written
// sequences for kill handling and reset in the middle of a request.
module tb_hella_cache_master_core;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [6:0]  cmd_tag;
  logic [4:0]  cmd_cmd;
  logic [2:0]  cmd_typ;
  logic [31:0] cmd_data;
  logic [3:0]  cmd_mask;
  logic        kill_clear;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        req_valid;
  logic [6:0]  req_tag;
  logic [4:0]  req_cmd;
  logic [2:0]  req_typ;
  logic [31:0] req_data;
  logic [3:0]  req_data_mask;
  logic        req_kill;
  logic        rsp_valid;
  logic        rsp_nack;
  logic [6:0]  rsp_tag;
  logic [2:0]  rsp_typ;
  logic [31:0] rsp_data;
  logic        out_valid;
  logic        out_nack;
  logic [6:0]  out_tag;
  logic [2:0]  out_typ;
  logic [31:0] out_data;

  hella_cache_master_core dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_tag(cmd_tag), .cmd_cmd(cmd_cmd), .cmd_typ(cmd_typ),
    .cmd_data(cmd_data), .cmd_mask(cmd_mask), .kill_clear(kill_clear),
    .req_addr(req_addr), .req_ready(req_ready), .req_valid(req_valid),
    .req_tag(req_tag), .req_cmd(req_cmd), .req_typ(req_typ),
    .req_data(req_data), .req_data_mask(req_data_mask), .req_kill(req_kill),
    .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_tag(rsp_tag),
    .rsp_typ(rsp_typ), .rsp_data(rsp_data),
    .out_valid(out_valid), .out_nack(out_nack), .out_tag(out_tag),
    .out_typ(out_typ), .out_data(out_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    logic [6:0]  tag;
    logic [4:0]  cmd;
    logic [2:0]  typ;
    logic [31:0] data;
    logic [3:0]  mask;
    int          wait_cycles;   // cycles req_ready stays low before handshake
  } cmd_vec_t;

  typedef struct {
    logic        v;
    logic        n;
    logic [6:0]  tag;
    logic [2:0]  typ;
    logic [31:0] data;
    logic        exp_kill;      // req_kill expected after the edge
  } rsp_vec_t;

  typedef struct {
    logic        nack;
    logic [6:0]  tag;
    logic [2:0]  typ;
    logic [31:0] data;
  } rsp_exp_t;

  int checks = 0;
  int errors = 0;

  cmd_vec_t req_q[$];
  rsp_exp_t rsp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Response scoreboard: expected capture recorded on the sampling edge.
  always @(posedge clock) begin
    if (!reset && (rsp_valid || rsp_nack))
      rsp_q.push_back('{nack: rsp_nack, tag: rsp_tag, typ: rsp_typ, data: rsp_data});
  end

  // Output monitors on the falling edge: response pop and request handshake pop.
  always @(negedge clock) begin
    if (!reset) begin
      if (rsp_q.size() > 0) begin
        rsp_exp_t e;
        e = rsp_q.pop_front();
        check("out_valid_pulse", out_valid, 1'b1);
        check("out_fields", {out_nack, out_tag, out_typ, out_data},
              {e.nack, e.tag, e.typ, e.data});
      end else begin
        check("out_valid_idle", out_valid, 1'b0);
      end
      if (req_valid && req_ready) begin
        if (req_q.size() == 0) begin
          check("req_unexpected_handshake", 1'b1, 1'b0);
        end else begin
          cmd_vec_t c;
          c = req_q.pop_front();
          check("req_fields", {req_addr, req_tag, req_cmd, req_typ, req_data, req_data_mask},
                {c.addr, c.tag, c.cmd, c.typ, c.data, c.mask});
        end
      end
    end
  end

  task automatic wait_cmd_ready();
    for (int i = 0; i < 20 && !cmd_ready; i++) tick();
    check("cmd_ready_timeout", cmd_ready, 1'b1);
  endtask

  // Issue one command and hold req_ready low for wait_cycles cycles.
  task automatic do_req(input cmd_vec_t c);
    wait_cmd_ready();
    cmd_valid = 1'b1;
    cmd_addr = c.addr; cmd_tag = c.tag; cmd_cmd = c.cmd;
    cmd_typ = c.typ; cmd_data = c.data; cmd_mask = c.mask;
    tick();
    req_q.push_back(c);
    // Garbage command kept valid: must be ignored while busy.
    cmd_addr = $urandom; cmd_tag = 7'($urandom); cmd_data = $urandom;
    cmd_cmd = 5'($urandom); cmd_typ = 3'($urandom); cmd_mask = 4'($urandom);
    check("busy_cmd_ready", cmd_ready, 1'b0);
    for (int i = 0; i < c.wait_cycles; i++) begin
      check("req_hold", {req_valid, req_addr, req_tag, req_cmd, req_typ, req_data, req_data_mask},
            {1'b1, c.addr, c.tag, c.cmd, c.typ, c.data, c.mask});
      tick();
    end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    check("post_hs_cleared", {req_valid, req_addr, req_tag, req_cmd, req_typ, req_data_mask, req_kill}, '0);
    check("post_hs_data", req_data, c.data);
    check("gap_cmd_ready", cmd_ready, 1'b0);
    tick();
    cmd_valid = 1'b0;
    check("gap_ignores_cmd", req_valid, 1'b0);
    check("idle_cmd_ready", cmd_ready, 1'b1);
  endtask

  task automatic send_rsp(input logic v, input logic n, input logic [6:0] tag,
                          input logic [2:0] typ, input logic [31:0] data);
    rsp_valid = v; rsp_nack = n; rsp_tag = tag; rsp_typ = typ; rsp_data = data;
    tick();
    rsp_valid = 1'b0; rsp_nack = 1'b0;
    rsp_tag = '0; rsp_typ = '0; rsp_data = '0;
  endtask

  cmd_vec_t cmd_tbl[3];
  rsp_vec_t rsp_tbl[4];

  initial begin
    cmd_tbl[0] = '{32'h0000_1000, 7'd5,    5'd1,  3'd3, 32'hDEAD_BEEF, 4'hF, 1};
    cmd_tbl[1] = '{32'h0000_2004, 7'd9,    5'd0,  3'd2, 32'h0000_0000, 4'h0, 10};
    cmd_tbl[2] = '{32'hFFFF_FFFC, 7'h7F,   5'h1F, 3'd7, 32'hA5A5_5A5A, 4'h9, 0};

    rsp_tbl[0] = '{1'b1, 1'b0, 7'd5,  3'd3, 32'h1234_5678, 1'b0};
    rsp_tbl[1] = '{1'b0, 1'b1, 7'h7F, 3'd7, 32'hFFFF_FFFF, 1'b1};
    rsp_tbl[2] = '{1'b1, 1'b0, 7'd0,  3'd0, 32'h0000_0000, 1'b1};
    rsp_tbl[3] = '{1'b1, 1'b1, 7'h2A, 3'd1, 32'hA5A5_A5A5, 1'b1};

    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_tag = '0; cmd_cmd = '0;
    cmd_typ = '0; cmd_data = '0; cmd_mask = '0; kill_clear = 1'b0; req_ready = 1'b0;
    rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_tag = '0; rsp_typ = '0; rsp_data = '0;

    tick(); tick();
    check("reset_outputs", {cmd_ready, req_valid, req_addr, req_tag, req_cmd, req_typ,
          req_data, req_data_mask, req_kill, out_valid, out_nack, out_tag, out_typ, out_data}, '0);
    reset = 1'b0;
    #1;
    check("cmd_ready_after_reset", cmd_ready, 1'b1);

    // Command table.
    foreach (cmd_tbl[i]) do_req(cmd_tbl[i]);

    // Response table with an idle cycle between entries.
    foreach (rsp_tbl[i]) begin
      send_rsp(rsp_tbl[i].v, rsp_tbl[i].n, rsp_tbl[i].tag, rsp_tbl[i].typ, rsp_tbl[i].data);
      check("rsp_kill", req_kill, rsp_tbl[i].exp_kill);
      tick();
      check("out_data_hold", out_data, rsp_tbl[i].data);
    end

    // kill_clear pulse drops req_kill.
    kill_clear = 1'b1; tick(); kill_clear = 1'b0;
    check("kill_cleared", req_kill, 1'b0);

    // Nack and kill_clear on the same edge: nack wins.
    kill_clear = 1'b1;
    send_rsp(1'b0, 1'b1, 7'd3, 3'd2, 32'h0BAD_F00D);
    kill_clear = 1'b0;
    check("kill_nack_priority", req_kill, 1'b1);
    tick();
    check("kill_holds", req_kill, 1'b1);

    // Handshake of the next request clears req_kill (checked inside do_req).
    do_req('{32'h0000_3000, 7'd1, 5'd2, 3'd1, 32'hCAFE_0001, 4'h3, 2});

    // Reset in the middle of REQ aborts the request.
    wait_cmd_ready();
    cmd_valid = 1'b1; cmd_addr = 32'h0000_4000; cmd_tag = 7'd11; cmd_data = 32'h1111_2222;
    tick();
    cmd_valid = 1'b0;
    check("mid_req_valid", req_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_req", {req_valid, req_addr, req_tag, cmd_ready}, '0);
    req_q.delete();
    tick();
    reset = 1'b0;
    #1;
    check("cmd_ready_after_abort", cmd_ready, 1'b1);
    tick();
    check("no_retry", req_valid, 1'b0);
    do_req('{32'h0000_5000, 7'd12, 5'd1, 3'd3, 32'h3333_4444, 4'hC, 1});

    tick(); tick();
    check("req_q_drained", req_q.size(), 0);
    check("rsp_q_drained", rsp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
